clk_divider: RTL

//  Programmable integer clock divider; consumes the free-running clock from the clk generator.

---
 rtl/clk_divider_pkg.sv | 5 +
 rtl/clk_divider_if.sv | 12 +
 rtl/clk_divider_shadow.sv | 32 +++
 rtl/clk_divider.sv | 60 ++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg: FSM state encodings and divisor limits shared by the divider and its bench.
package clk_divider_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_divider_if.sv
// clk_divider_if: run control, divisor load handshake and divided-clock outputs.
interface clk_divider_if #(parameter int WIDTH = 8);
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic             busy;
    logic             clk_out;
    logic             tick;
    modport master (output enable, div_in, div_load, input div_ack, busy, clk_out, tick);
    modport slave  (input enable, div_in, div_load, output div_ack, busy, clk_out, tick);
endinterface

// File: rtl/clk_divider_shadow.sv
// clk_divider_shadow: holds a captured divisor until the top applies it, with busy/ack handshake.
module clk_divider_shadow
    import clk_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             apply,
    output logic [WIDTH-1:0] pending,
    output logic             busy,
    output logic             ack
);
    // a fresh capture always wins over an apply on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= load;
            if (load) begin
                pending <= din < WIDTH'(MIN_DIV) ? WIDTH'(MIN_DIV) : din;
                busy    <= 1'b1;
            end else if (apply) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_divider.sv
// clk_divider: programmable integer divider producing a registered divided clock and period tick.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_divider_if.slave   bus
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx, div, div_nx, pending;
    logic             run, wrap, apply, busy, ack, clk_nx, clk_q, tick_q;

    clk_divider_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (bus.div_load),
        .din     (bus.div_in),
        .apply   (apply),
        .pending (pending),
        .busy    (busy),
        .ack     (ack)
    );

    // outputs are precomputed from next-state values so they stay registered
    always_comb begin
        run      = state != IDLE;
        wrap     = run && cnt == div - WIDTH'(1);
        apply    = busy && (!run || wrap);
        div_nx   = apply ? pending : div;
        cnt_nx   = (wrap || !run) ? '0 : cnt + WIDTH'(1);
        state_nx = state == IDLE ? (bus.enable ? RUN : IDLE)
                 : bus.enable ? RUN
                 : (state == DRAIN && wrap) ? IDLE : DRAIN;
        clk_nx   = state_nx != IDLE && cnt_nx < div_nx - (div_nx >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            div    <= WIDTH'(DEFAULT_DIV);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            div    <= div_nx;
            clk_q  <= clk_nx;
            tick_q <= wrap;
        end
    end

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
    assign bus.div_ack = ack;
    assign bus.busy    = busy;
endmodule
